pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush scheduler for the 5-stage core.
- Generates cache_stall, load_use_stall and pipeline_flush for the ID/EX pipeline register, and matching hold controls for PC and IF/ID.
- Tracks outstanding I-cache/D-cache misses and defers branch flushes that arrive during a cache freeze.
- Monitors stall length and reports a sticky timeout.

---
 rtl/pipeline_hazard_ctrl_if.sv | 61 ++++++
 rtl/pipeline_hazard_ctrl.sv | 139 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
//
// Bundles the signals exchanged between the 5-stage core and its hazard
// controller. The core side uses `master`. The hazard controller uses `slave`.
//
// Core -> controller:
//   id_rs1_addr/valid, id_rs2_addr/valid  source registers of the ID instruction
//   ex_rd_addr/valid, ex_opcode           destination and opcode at the ID/EX output
//   branch_flush_req                      EX redirect (taken branch or jump)
//   icache_miss/ready, dcache_miss/ready  cache miss and refill-done pulses
//
// Controller -> core:
//   cache_stall, load_use_stall, pipeline_flush, pc_hold
//   stall_cycles, stall_timeout
//   perf_*_cnt  event counters (tied to 0 unless PIPE_HAZARD_PERF_EN is defined)
// -----------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 8
);
    logic [4:0]       id_rs1_addr;
    logic             id_rs1_valid;
    logic [4:0]       id_rs2_addr;
    logic             id_rs2_valid;
    logic [4:0]       ex_rd_addr;
    logic             ex_rd_valid;
    logic [6:0]       ex_opcode;
    logic             branch_flush_req;
    logic             icache_miss;
    logic             icache_ready;
    logic             dcache_miss;
    logic             dcache_ready;

    logic             cache_stall;
    logic             load_use_stall;
    logic             pipeline_flush;
    logic             pc_hold;
    logic [CNT_W-1:0] stall_cycles;
    logic             stall_timeout;
    logic [31:0]      perf_cache_stall_cnt;
    logic [31:0]      perf_load_use_cnt;
    logic [31:0]      perf_flush_cnt;

    modport master (
        output id_rs1_addr, id_rs1_valid, id_rs2_addr, id_rs2_valid,
               ex_rd_addr, ex_rd_valid, ex_opcode, branch_flush_req,
               icache_miss, icache_ready, dcache_miss, dcache_ready,
        input  cache_stall, load_use_stall, pipeline_flush, pc_hold,
               stall_cycles, stall_timeout,
               perf_cache_stall_cnt, perf_load_use_cnt, perf_flush_cnt
    );

    modport slave (
        input  id_rs1_addr, id_rs1_valid, id_rs2_addr, id_rs2_valid,
               ex_rd_addr, ex_rd_valid, ex_opcode, branch_flush_req,
               icache_miss, icache_ready, dcache_miss, dcache_ready,
        output cache_stall, load_use_stall, pipeline_flush, pc_hold,
               stall_cycles, stall_timeout,
               perf_cache_stall_cnt, perf_load_use_cnt, perf_flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central stall/flush scheduler for the 5-stage core.
// - cache_stall freezes the whole pipe while an I- or D-cache miss is pending.
// - pipeline_flush squashes IF/ID and ID/EX on a redirect. A redirect that
//   arrives during a freeze is remembered and issued once the freeze ends.
// - load_use_stall inserts one bubble for a load-use dependency.
// - pc_hold holds PC and IF/ID whenever either stall is active.
// - stall_cycles counts consecutive freeze cycles and saturates.
// - stall_timeout is a sticky flag. It is set once a freeze reaches
//   STALL_TIMEOUT cycles.
//
// Ports:
//   clk  core clock
//   rst  synchronous, active-low reset; all outputs read 0 while it is low
//   hz   pipeline_hazard_ctrl_if.slave (see the interface file)
//
// Optional feature: define PIPE_HAZARD_PERF_EN to enable three 32-bit
// wrapping event counters on the perf_* ports. Without it the ports are
// tied to 0 and no counter flops exist.
//
// Priority: cache_stall > pipeline_flush > load_use_stall.
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter logic [6:0] LOAD_OPCODE   = 7'b0000011,
    parameter int          CNT_W         = 8,
    parameter int          STALL_TIMEOUT = 255
) (
    input logic                   clk,
    input logic                   rst,
    pipeline_hazard_ctrl_if.slave hz
);

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(STALL_TIMEOUT);

    logic             i_pend_q, i_pend_d;
    logic             d_pend_q, d_pend_d;
    logic             flush_pend_q, flush_pend_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic             stall_timeout_q, stall_timeout_d;

    logic             cache_stall_c;
    logic             hazard_c;
    logic             flush_c;
    logic             load_use_c;

    always_comb begin
        // NOTE: every signal is assigned on all paths through this block, so no latch is inferred.
        cache_stall_c = hz.icache_miss | hz.dcache_miss | i_pend_q | d_pend_q;

        hazard_c = hz.ex_rd_valid
                 & (hz.ex_opcode == LOAD_OPCODE)
                 & (hz.ex_rd_addr != 5'd0)
                 & ((hz.id_rs1_valid & (hz.id_rs1_addr == hz.ex_rd_addr))
                  | (hz.id_rs2_valid & (hz.id_rs2_addr == hz.ex_rd_addr)));

        // A redirect squashes the dependent instruction, so no bubble is needed with a flush.
        flush_c    = (hz.branch_flush_req | flush_pend_q) & ~cache_stall_c;
        load_use_c = hazard_c & ~cache_stall_c & ~flush_c;

        // A new miss wins over a ready in the same cycle. A ready with nothing pending does nothing.
        i_pend_d = hz.icache_miss | (i_pend_q & ~hz.icache_ready);
        d_pend_d = hz.dcache_miss | (d_pend_q & ~hz.dcache_ready);

        // Redirects seen during a freeze merge into a single deferred flush.
        // That flush is consumed in the cycle it is issued.
        flush_pend_d = (flush_pend_q | (hz.branch_flush_req & cache_stall_c)) & ~flush_c;

        if (!cache_stall_c) begin
            stall_cycles_d = '0;
        end else if (&stall_cycles_q) begin
            stall_cycles_d = stall_cycles_q;
        end else begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end

        stall_timeout_d = stall_timeout_q | (cache_stall_c & (stall_cycles_q == TIMEOUT_VAL));
    end

    // NOTE: reset is sampled on the clock edge (synchronous), so rst does not appear in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst) begin
            i_pend_q        <= 1'b0;
            d_pend_q        <= 1'b0;
            flush_pend_q    <= 1'b0;
            stall_cycles_q  <= '0;
            stall_timeout_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every flop see pre-edge values, matching real registers.
            i_pend_q        <= i_pend_d;
            d_pend_q        <= d_pend_d;
            flush_pend_q    <= flush_pend_d;
            stall_cycles_q  <= stall_cycles_d;
            stall_timeout_q <= stall_timeout_d;
        end
    end

    // All outputs read 0 while reset is held, whatever the inputs are doing.
    assign hz.cache_stall    = rst & cache_stall_c;
    assign hz.load_use_stall = rst & load_use_c;
    assign hz.pipeline_flush = rst & flush_c;
    assign hz.pc_hold        = rst & (cache_stall_c | load_use_c);
    assign hz.stall_cycles   = rst ? stall_cycles_q : '0;
    assign hz.stall_timeout  = rst & stall_timeout_q;

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] perf_cs_q, perf_cs_d;
    logic [31:0] perf_lu_q, perf_lu_d;
    logic [31:0] perf_fl_q, perf_fl_d;

    always_comb begin
        perf_cs_d = perf_cs_q + {31'd0, cache_stall_c};
        perf_lu_d = perf_lu_q + {31'd0, load_use_c};
        perf_fl_d = perf_fl_q + {31'd0, flush_c};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_cs_q <= 32'd0;
            perf_lu_q <= 32'd0;
            perf_fl_q <= 32'd0;
        end else begin
            perf_cs_q <= perf_cs_d;
            perf_lu_q <= perf_lu_d;
            perf_fl_q <= perf_fl_d;
        end
    end

    assign hz.perf_cache_stall_cnt = rst ? perf_cs_q : 32'd0;
    assign hz.perf_load_use_cnt    = rst ? perf_lu_q : 32'd0;
    assign hz.perf_flush_cnt       = rst ? perf_fl_q : 32'd0;
`else
    assign hz.perf_cache_stall_cnt = 32'd0;
    assign hz.perf_load_use_cnt    = 32'd0;
    assign hz.perf_flush_cnt       = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Inputs are driven 1 time unit after posedge. Outputs are sampled at negedge.
// Each cycle pushes its expected outputs to a queue. The sampler pops and
// compares them. A running count of expected stall/bubble/flush cycles
// provides the reference for the perf counters.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    localparam int         CNT_W = 8;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_R  = 7'b0110011;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

    pipeline_hazard_ctrl #(
        .LOAD_OPCODE  (OP_LD),
        .CNT_W        (CNT_W),
        .STALL_TIMEOUT(255)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hz (hz)
    );

    typedef struct packed {
        logic [4:0] rs1; logic rs1_v;
        logic [4:0] rs2; logic rs2_v;
        logic [4:0] rd;  logic rd_v;
        logic [6:0] op;
        logic br; logic im; logic ir; logic dm; logic dr;
    } stim_t;

    typedef struct packed {
        logic cs; logic lu; logic fl; logic ph; logic to;
        logic [7:0] sc;
    } exp_t;

    typedef struct { stim_t s; exp_t e; string name; } vec_t;
    typedef struct { exp_t e; string name; } sb_t;

    sb_t   sb_q[$];
    vec_t  vecs[11];
    int    errors = 0;
    int    checks = 0;
    int    m_cs = 0, m_lu = 0, m_fl = 0;   // reference perf counts
    stim_t IDLE;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic stim_t ld(input logic [4:0] rs1, input logic rs1v,
                                 input logic [4:0] rs2, input logic rs2v,
                                 input logic [4:0] rd, input logic rdv, input logic [6:0] op);
        stim_t s;
        s = '0;
        s.rs1 = rs1; s.rs1_v = rs1v; s.rs2 = rs2; s.rs2_v = rs2v;
        s.rd = rd; s.rd_v = rdv; s.op = op;
        return s;
    endfunction

    function automatic stim_t ctl(input logic br, input logic im, input logic ir,
                                  input logic dm, input logic dr);
        stim_t s;
        s = '0;
        s.br = br; s.im = im; s.ir = ir; s.dm = dm; s.dr = dr;
        return s;
    endfunction

    function automatic exp_t ex(input logic cs, input logic lu, input logic fl,
                                input logic ph, input logic to, input logic [7:0] sc);
        exp_t e;
        e.cs = cs; e.lu = lu; e.fl = fl; e.ph = ph; e.to = to; e.sc = sc;
        return e;
    endfunction

    task automatic apply(input stim_t s);
        hz.id_rs1_addr      = s.rs1;
        hz.id_rs1_valid     = s.rs1_v;
        hz.id_rs2_addr      = s.rs2;
        hz.id_rs2_valid     = s.rs2_v;
        hz.ex_rd_addr       = s.rd;
        hz.ex_rd_valid      = s.rd_v;
        hz.ex_opcode        = s.op;
        hz.branch_flush_req = s.br;
        hz.icache_miss      = s.im;
        hz.icache_ready     = s.ir;
        hz.dcache_miss      = s.dm;
        hz.dcache_ready     = s.dr;
    endtask

    function automatic logic [95:0] perf_exp();
`ifdef PIPE_HAZARD_PERF_EN
        return {32'(m_cs), 32'(m_lu), 32'(m_fl)};
`else
        return 96'd0;
`endif
    endfunction

    task automatic sample();
        sb_t item;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: got empty queue expected an entry");
        end else begin
            item = sb_q.pop_front();
            check(item.name,
                  {hz.cache_stall, hz.load_use_stall, hz.pipeline_flush, hz.pc_hold,
                   hz.stall_timeout, hz.stall_cycles},
                  item.e);
            check({item.name, "_perf"},
                  {hz.perf_cache_stall_cnt, hz.perf_load_use_cnt, hz.perf_flush_cnt},
                  perf_exp());
            m_cs += int'(item.e.cs);
            m_lu += int'(item.e.lu);
            m_fl += int'(item.e.fl);
        end
    endtask

    task automatic cyc(input stim_t s, input exp_t e, input string name);
        sb_t item;
        @(posedge clk);
        #1;
        apply(s);
        item.e    = e;
        item.name = name;
        sb_q.push_back(item);
        @(negedge clk);
        sample();
    endtask

    // Two reset cycles with a miss driven; every output must read 0.
    task automatic do_reset();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            rst = 1'b0;
            apply(ctl(1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
            @(negedge clk);
            check("reset_outputs",
                  {hz.cache_stall, hz.load_use_stall, hz.pipeline_flush, hz.pc_hold,
                   hz.stall_timeout, hz.stall_cycles,
                   hz.perf_cache_stall_cnt, hz.perf_load_use_cnt, hz.perf_flush_cnt},
                  128'd0);
        end
        m_cs = 0; m_lu = 0; m_fl = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        apply(IDLE);
    endtask

    initial begin
        IDLE = '0;
        rst  = 1'b0;
        apply(IDLE);

        // Load-use table: no cache activity, so stall_cycles stays 0.
        vecs[0]  = '{ld(5'd0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, OP_LD),  ex(0,1,0,1,0,8'd0), "lu_rs2"};
        vecs[1]  = '{IDLE,                                           ex(0,0,0,0,0,8'd0), "lu_bubble_clears"};
        vecs[2]  = '{ld(5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, OP_LD),  ex(0,0,0,0,0,8'd0), "lu_rd_zero"};
        vecs[3]  = '{ld(5'd0, 1'b0, 5'd5, 1'b0, 5'd5, 1'b1, OP_LD),  ex(0,0,0,0,0,8'd0), "lu_rs2_invalid"};
        vecs[4]  = '{ld(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, OP_LD),  ex(0,1,0,1,0,8'd0), "lu_rs1"};
        vecs[5]  = '{ld(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, OP_R),   ex(0,0,0,0,0,8'd0), "lu_not_load"};
        vecs[6]  = '{ld(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b0, OP_LD),  ex(0,0,0,0,0,8'd0), "lu_rd_invalid"};
        vecs[7]  = '{ld(5'd3, 1'b1, 5'd9, 1'b1, 5'd7, 1'b1, OP_LD),  ex(0,0,0,0,0,8'd0), "lu_no_match"};
        vecs[8]  = '{ld(5'd0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, OP_LD),  ex(0,0,1,0,0,8'd0), "flush_beats_lu"};
        vecs[9]  = '{ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0),              ex(0,0,1,0,0,8'd0), "flush_alone"};
        vecs[10] = '{ld(5'd31, 1'b1, 5'd31, 1'b1, 5'd31, 1'b1, OP_LD), ex(0,1,0,1,0,8'd0), "lu_r31_both"};
        vecs[8].s.br = 1'b1;

        do_reset();

        // I-cache miss: stall through the ready cycle, counter peaks at 5.
        cyc(ctl(0,1,0,0,0), ex(1,0,0,1,0,8'd0), "imiss_cycle");
        for (int i = 1; i <= 3; i++)
            cyc(IDLE, ex(1,0,0,1,0,8'(i)), "imiss_wait");
        cyc(ctl(0,0,1,0,0), ex(1,0,0,1,0,8'd4), "iready_cycle");
        cyc(IDLE, ex(0,0,0,0,0,8'd5), "istall_dropped");
        cyc(IDLE, ex(0,0,0,0,0,8'd0), "icnt_cleared");

        for (int i = 0; i < 11; i++)
            cyc(vecs[i].s, vecs[i].e, vecs[i].name);

        // Deferred flush: two redirects during a D-miss merge into one pulse.
        // Hazards during the freeze and the flush cycle give no bubble.
        cyc(ctl(0,0,0,1,0), ex(1,0,0,1,0,8'd0), "dmiss_cycle");
        cyc(ctl(1,0,0,0,0), ex(1,0,0,1,0,8'd1), "dflush_req1");
        cyc(vecs[0].s,      ex(1,0,0,1,0,8'd2), "dstall_hides_lu");
        cyc(ctl(1,0,0,0,0), ex(1,0,0,1,0,8'd3), "dflush_req2");
        cyc(ctl(0,0,0,0,1), ex(1,0,0,1,0,8'd4), "dready_cycle");
        cyc(vecs[0].s,      ex(0,0,1,0,0,8'd5), "deferred_flush");
        cyc(IDLE,           ex(0,0,0,0,0,8'd0), "flush_single");
        cyc(IDLE,           ex(0,0,0,0,0,8'd0), "flush_done");

        // Overlapping misses: the stall holds until after the last ready.
        cyc(ctl(0,1,0,1,0), ex(1,0,0,1,0,8'd0), "ovl_miss");
        cyc(IDLE,           ex(1,0,0,1,0,8'd1), "ovl_wait");
        cyc(ctl(0,0,1,0,0), ex(1,0,0,1,0,8'd2), "ovl_iready");
        cyc(IDLE,           ex(1,0,0,1,0,8'd3), "ovl_dpend1");
        cyc(IDLE,           ex(1,0,0,1,0,8'd4), "ovl_dpend2");
        cyc(ctl(0,0,0,0,1), ex(1,0,0,1,0,8'd5), "ovl_dready");
        cyc(IDLE,           ex(0,0,0,0,0,8'd6), "ovl_released");
        cyc(IDLE,           ex(0,0,0,0,0,8'd0), "ovl_cnt_cleared");

        // Ready with nothing pending is ignored. Miss and ready together set pend.
        cyc(ctl(0,0,1,0,1), ex(0,0,0,0,0,8'd0), "ready_no_pend");
        cyc(IDLE,           ex(0,0,0,0,0,8'd0), "ready_no_pend_after");
        cyc(ctl(0,1,1,0,0), ex(1,0,0,1,0,8'd0), "miss_ready_same");
        cyc(IDLE,           ex(1,0,0,1,0,8'd1), "miss_ready_pend");
        cyc(ctl(0,0,1,0,0), ex(1,0,0,1,0,8'd2), "miss_ready_clear");
        cyc(IDLE,           ex(0,0,0,0,0,8'd3), "miss_ready_done");

        // A reset in the middle of a miss drops the pending state.
        cyc(ctl(0,1,0,0,0), ex(1,0,0,1,0,8'd0), "midrst_miss");
        cyc(IDLE,           ex(1,0,0,1,0,8'd1), "midrst_wait");
        do_reset();
        cyc(IDLE,           ex(0,0,0,0,0,8'd0), "midrst_dropped");

        // Long miss: the counter saturates and the sticky timeout is set.
        cyc(ctl(0,1,0,0,0), ex(1,0,0,1,0,8'd0), "to_miss");
        for (int i = 1; i < 300; i++)
            cyc(IDLE, ex(1,0,0,1,(i >= 256), (i > 255) ? 8'd255 : 8'(i)), "to_run");
        cyc(ctl(0,0,1,0,0), ex(1,0,0,1,1,8'd255), "to_ready");
        cyc(IDLE,           ex(0,0,0,0,1,8'd255), "to_released");
        cyc(IDLE,           ex(0,0,0,0,1,8'd0),   "to_sticky");
`ifdef PIPE_HAZARD_PERF_EN
        check("perf_stall_len", {96'd0, hz.perf_cache_stall_cnt}, 128'd301);
`else
        check("perf_tied_off", {96'd0, hz.perf_cache_stall_cnt}, 128'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
